cdc_hs_tx: RTL and testbench
============================

// Module: cdc_hs_tx
// PURPOSE
//  Source-domain (transmit) end of a 4-phase req/ack clock-domain crossing.
//  Captures one DATA_W word, holds it stable on data_out, raises req_out and
//  waits for the far domain's ack, which returns unsynchronised.
//  ack_async passes through an internal SYNC_STAGES flop chain, the same
//  2-FF scheme the receive side uses on req, before any logic sees it.
//  Sits between a local producer (valid/ready) and the crossing wires.
// PARAMETERS
//  DATA_W       8    width of the transferred word
//  SYNC_STAGES  2    flops in ack synchroniser chain (min 2)
//  TIMEOUT      255  cycles without the expected ack before timeout_err sets
// PORTS
//  clk_src      in   1       source-domain clock, rising edge
//  rst          in   1       synchronous, active-high reset
//  in_valid     in   1       producer has a word
//  in_data      in   DATA_W  producer word
//  in_ready     out  1       block can accept (IDLE only)
//  req_out      out  1       request level to far domain, flop driven
//  data_out     out  DATA_W  crossing data bus, flop driven
//  ack_async    in   1       ack level from far domain, asynchronous
//  xfer_done    out  1       1-cycle pulse: handshake fully completed
//  busy         out  1       high when state != IDLE
//  timeout_err  out  1       sticky: ack phase exceeded TIMEOUT cycles
// BEHAVIOUR
//  Reset (rst high at edge): state=IDLE, req_out=0, data_out=0, sync chain=0,
//   xfer_done=0, timeout_err=0, counter=0. Mid-transfer reset aborts at once.
//  ack_s = last flop of sync chain; no logic uses ack_async directly.
//  in_ready = (state==IDLE) & ~rst; busy = (state!=IDLE).
//  States:
//   IDLE:    accept when in_valid&in_ready -> data_out<=in_data, req_out<=1,
//            go REQ (req_out high on the accept edge).
//   REQ:     if ack_s==1 -> req_out<=0, go ACK_LO.
//   ACK_LO:  if ack_s==0 -> xfer_done<=1 for one cycle, go IDLE.
//  Latency: req_out falls on the (SYNC_STAGES+1)th edge after ack_async is
//   first sampled high. Re-entry to IDLE likewise after ack falls.
//  Next accept is possible the cycle xfer_done is high (back-to-back).
//  data_out changes only on accept; stable through REQ and ACK_LO.
//  in_data/in_valid are ignored outside IDLE.
//  ack_s already high on entry to REQ (protocol violation): treated as
//   ack, no special handling.
//  Timeout counter: cleared on every state change, increments in REQ and
//   ACK_LO, saturates at TIMEOUT. On reaching TIMEOUT, timeout_err<=1.
//   The handshake keeps waiting with no abort. Only rst clears timeout_err.
//  At most one word is in flight; no internal buffering beyond data_out.
// TESTING
//  T1 reset: rst=1 2 cycles -> req_out=0, data_out=0, in_ready=0 during,
//     in_ready=1 after, busy=0, timeout_err=0.
//  T2 single xfer: in_data=8'hA5 valid 1 cycle; ack_async rises 3 cycles
//     after req_out -> data_out=A5, req_out falls 3 edges after ack sampled,
//     xfer_done one pulse after ack drops.
//  T3 back-to-back: valid held with 8'h01,8'h02 -> second accepted on the
//     xfer_done cycle; data_out A->B change only at accept edges.
//  T4 data hold: toggle in_data every cycle during REQ/ACK_LO -> data_out
//     constant.
//  T5 timeout: TIMEOUT=16, ack never rises -> timeout_err=1 after 16 cycles
//     in REQ, req_out stays 1. Then ack completes normally with err still 1.
//  T6 reset mid-xfer: rst in ACK_LO -> next cycle IDLE, req_out=0, no
//     xfer_done pulse.

Source files
------------

// File: rtl/cdc_hs_tx.sv
// Transmit end of a 4-phase req/ack crossing: holds one word on data_out under
// req_out until the synchronised ack has risen and then fallen again.
module cdc_hs_tx #(
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 255
) (
  input  logic              clk_src,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              req_out,
  output logic [DATA_W-1:0] data_out,
  input  logic              ack_async,
  output logic              xfer_done,
  output logic              busy,
  output logic              timeout_err
);

  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_ACK_LO
  } state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [SYNC_STAGES-1:0] r_ack_sync;
  logic                   r_req;
  logic                   w_req_nxt;
  logic [DATA_W-1:0]      r_data;
  logic [DATA_W-1:0]      w_data_nxt;
  logic                   r_done;
  logic                   w_done_nxt;
  logic                   r_err;
  logic                   w_err_nxt;
  logic [CNT_W-1:0]       r_cnt;
  logic [CNT_W-1:0]       w_cnt_nxt;
  logic                   w_ack_s;
  logic                   w_accept;

  // ack arrives from another clock domain; only the last flop is ever used.
  always_ff @(posedge clk_src) begin
    if (rst) r_ack_sync <= '0;
    else     r_ack_sync <= {r_ack_sync[SYNC_STAGES-2:0], ack_async};
  end

  assign w_ack_s  = r_ack_sync[SYNC_STAGES-1];
  assign in_ready = (r_state == ST_IDLE) && !rst;
  assign w_accept = in_valid && in_ready;

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    w_state_nxt = r_state;
    w_req_nxt   = r_req;
    w_data_nxt  = r_data;
    w_done_nxt  = 1'b0;
    w_err_nxt   = r_err;
    w_cnt_nxt   = r_cnt;

    unique case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_data_nxt  = in_data;
          w_req_nxt   = 1'b1;
          w_state_nxt = ST_REQ;
        end
      end
      ST_REQ: begin
        if (w_ack_s) begin
          w_req_nxt   = 1'b0;
          w_state_nxt = ST_ACK_LO;
        end
      end
      ST_ACK_LO: begin
        if (!w_ack_s) begin
          w_done_nxt  = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase

    // Wait counter measures time spent in the current ack phase only.
    if (w_state_nxt != r_state)
      w_cnt_nxt = '0;
    else if (r_state != ST_IDLE && r_cnt != CNT_MAX)
      w_cnt_nxt = r_cnt + 1'b1;

    if (w_state_nxt != ST_IDLE && w_cnt_nxt == CNT_MAX)
      w_err_nxt = 1'b1;
  end

  // NOTE: state registers use non-blocking assignment so all flops update together.
  always_ff @(posedge clk_src) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_req   <= 1'b0;
      r_data  <= '0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_req   <= w_req_nxt;
      r_data  <= w_data_nxt;
      r_done  <= w_done_nxt;
      r_err   <= w_err_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  assign req_out     = r_req;
  assign data_out    = r_data;
  assign xfer_done   = r_done;
  assign busy        = (r_state != ST_IDLE);
  assign timeout_err = r_err;

endmodule

// File: tb/tb_cdc_hs_tx.sv
// Bench for cdc_hs_tx: directed handshake scenarios plus random traffic, all
// checked every cycle against a transaction-level model of the transmitter.
module tb_cdc_hs_tx;

  localparam int DATA_W      = 8;
  localparam int SYNC_STAGES = 2;
  localparam int TIMEOUT     = 16;

  logic              clk_src = 1'b0;
  logic              rst;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              req_out;
  logic [DATA_W-1:0] data_out;
  logic              ack_async;
  logic              xfer_done;
  logic              busy;
  logic              timeout_err;

  cdc_hs_tx #(
    .DATA_W     (DATA_W),
    .SYNC_STAGES(SYNC_STAGES),
    .TIMEOUT    (TIMEOUT)
  ) dut (
    .clk_src    (clk_src),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .req_out    (req_out),
    .data_out   (data_out),
    .ack_async  (ack_async),
    .xfer_done  (xfer_done),
    .busy       (busy),
    .timeout_err(timeout_err)
  );

  always #5 clk_src = ~clk_src;

  int n_cmp = 0;
  int n_bad = 0;

  // Model: phase 0 = idle, 1 = waiting for ack high, 2 = waiting for ack low.
  int              m_phase;
  bit              m_req;
  bit [DATA_W-1:0] m_data;
  bit              m_done;
  bit              m_err;
  int              m_wait;
  bit              m_hist[$];

  // Far-domain responder.
  int ack_dly_hi, ack_dly_lo, ack_cnt;
  bit ack_block;

  // Edge-number trace used for latency checks.
  int edge_no, ack_rise_edge, ack_fall_edge, req_fall_edge, done_edge, done_count;
  bit ack_last, req_last;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_phase = 0;
    m_req   = 1'b0;
    m_data  = '0;
    m_done  = 1'b0;
    m_err   = 1'b0;
    m_wait  = 0;
    m_hist.delete();
    for (int i = 0; i < SYNC_STAGES; i++) m_hist.push_back(1'b0);
  endfunction

  // The transmitter reacts at an edge to ack as sampled SYNC_STAGES edges earlier.
  function automatic void model_step();
    bit seen;
    if (rst) begin
      model_reset();
      return;
    end
    seen = m_hist.pop_front();
    m_hist.push_back(ack_async);
    m_done = 1'b0;
    case (m_phase)
      0: if (in_valid) begin m_data = in_data; m_req = 1'b1; m_phase = 1; m_wait = 0; end
      1: if (seen) begin m_req = 1'b0; m_phase = 2; m_wait = 0; end else m_wait++;
      default: if (!seen) begin m_done = 1'b1; m_phase = 0; m_wait = 0; end else m_wait++;
    endcase
    if (m_wait > TIMEOUT) m_wait = TIMEOUT;
    if (m_phase != 0 && m_wait == TIMEOUT) m_err = 1'b1;
  endfunction

  task automatic compare_all();
    check("in_ready",    in_ready,    (m_phase == 0) && !rst);
    check("req_out",     req_out,     m_req);
    check("data_out",    data_out,    m_data);
    check("xfer_done",   xfer_done,   m_done);
    check("busy",        busy,        m_phase != 0);
    check("timeout_err", timeout_err, m_err);
  endtask

  task automatic agent();
    if (!ack_async && req_out) begin
      if (!ack_block && ack_cnt >= ack_dly_hi) begin ack_async = 1'b1; ack_cnt = 0; end
      else ack_cnt++;
    end else if (ack_async && !req_out) begin
      if (ack_cnt >= ack_dly_lo) begin ack_async = 1'b0; ack_cnt = 0; end
      else ack_cnt++;
    end else begin
      ack_cnt = 0;
    end
  endtask

  // One clock: model advances at the rising edge, DUT is compared at the falling edge.
  task automatic cycle();
    @(posedge clk_src);
    edge_no++;
    if (ack_async && !ack_last) ack_rise_edge = edge_no;
    if (!ack_async && ack_last) ack_fall_edge = edge_no;
    ack_last = ack_async;
    model_step();
    @(negedge clk_src);
    compare_all();
    if (req_last && !req_out) req_fall_edge = edge_no;
    req_last = req_out;
    if (xfer_done) begin done_edge = edge_no; done_count++; end
    agent();
  endtask

  task automatic wait_done(input string tag, input int budget);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      cycle();
      seen = xfer_done;
    end
    check(tag, seen, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish (t=%0t)", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b1; in_data = 8'h5A; ack_async = 1'b0;
    ack_dly_hi = 2; ack_dly_lo = 2; ack_cnt = 0; ack_block = 1'b0;
    edge_no = 0; ack_rise_edge = 0; ack_fall_edge = 0; req_fall_edge = 0;
    done_edge = 0; done_count = 0; ack_last = 1'b0; req_last = 1'b0;
    model_reset();

    // T1: reset held two cycles, valid asserted but must be refused.
    repeat (2) cycle();
    check("t1_ready_in_rst", in_ready, 0);
    check("t1_data_rst", data_out, 0);
    check("t1_req_rst", req_out, 0);
    rst = 1'b0; in_valid = 1'b0;
    #1;
    check("t1_ready_after", in_ready, 1);
    check("t1_busy", busy, 0);
    check("t1_err", timeout_err, 0);
    cycle();

    // T2: single transfer of A5 with latency checks on both ack edges.
    done_count = 0;
    in_valid = 1'b1; in_data = 8'hA5;
    cycle();
    in_valid = 1'b0; in_data = 8'h00;
    check("t2_req_up", req_out, 1);
    check("t2_data", data_out, 8'hA5);
    wait_done("t2_done", 60);
    // The sampling edge counts as the first of the SYNC_STAGES+1 edges.
    check("t2_req_fall_lat", req_fall_edge - ack_rise_edge, SYNC_STAGES);
    check("t2_done_lat", done_edge - ack_fall_edge, SYNC_STAGES);
    repeat (3) cycle();
    check("t2_one_pulse", done_count, 1);

    // T3: back-to-back words with valid held high.
    in_valid = 1'b1; in_data = 8'h01;
    cycle();
    in_data = 8'h02;
    check("t3_first", data_out, 8'h01);
    wait_done("t3_done1", 60);
    check("t3_ready_on_done", in_ready, 1);
    check("t3_data_before", data_out, 8'h01);
    cycle();
    in_valid = 1'b0;
    check("t3_second", data_out, 8'h02);
    check("t3_req2", req_out, 1);
    wait_done("t3_done2", 60);
    check("t3_data_held", data_out, 8'h02);

    // T4: producer inputs churn while a word is in flight.
    ack_dly_hi = 5; ack_dly_lo = 5;
    in_valid = 1'b1; in_data = 8'hC3;
    cycle();
    for (int i = 0; i < 60 && !xfer_done; i++) begin
      in_valid = 1'($urandom_range(0, 1));
      in_data  = 8'($urandom);
      cycle();
    end
    in_valid = 1'b0;
    check("t4_done", xfer_done, 1);
    check("t4_hold", data_out, 8'hC3);
    cycle();

    // T5: ack withheld past TIMEOUT, then released.
    ack_block = 1'b1; ack_dly_hi = 0; ack_dly_lo = 1;
    in_valid = 1'b1; in_data = 8'h3C;
    cycle();
    in_valid = 1'b0;
    repeat (TIMEOUT - 1) cycle();
    check("t5_err_early", timeout_err, 0);
    cycle();
    check("t5_err_set", timeout_err, 1);
    check("t5_req_held", req_out, 1);
    repeat (5) cycle();
    check("t5_req_still", req_out, 1);
    ack_block = 1'b0;
    wait_done("t5_done", 60);
    check("t5_err_sticky", timeout_err, 1);
    check("t5_data", data_out, 8'h3C);

    // T6: reset while waiting for ack to fall.
    ack_dly_hi = 1; ack_dly_lo = 8;
    in_valid = 1'b1; in_data = 8'h96;
    cycle();
    in_valid = 1'b0;
    for (int i = 0; i < 30 && !(busy && !req_out); i++) cycle();
    check("t6_in_ack_lo", busy && !req_out, 1);
    rst = 1'b1; done_count = 0;
    cycle();
    rst = 1'b0;
    check("t6_idle", busy, 0);
    check("t6_req", req_out, 0);
    check("t6_err_clr", timeout_err, 0);
    repeat (15) cycle();
    check("t6_no_done", done_count, 0);

    // Random traffic with occasional long ack delays and resets.
    for (int t = 0; t < 4000; t++) begin
      in_valid = 1'($urandom_range(0, 1));
      in_data  = 8'($urandom);
      if (ack_cnt == 0) begin
        ack_dly_hi = ($urandom_range(0, 9) == 0) ? TIMEOUT + 4 : int'($urandom_range(0, 4));
        ack_dly_lo = ($urandom_range(0, 9) == 0) ? TIMEOUT + 4 : int'($urandom_range(0, 4));
      end
      rst = ($urandom_range(0, 299) == 0);
      cycle();
    end
    rst = 1'b0;
    in_valid = 1'b0;
    cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
